// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the five-stage core: tracks in-flight
// destinations in EX/MEM/WB and drives stall, flush and ID-stage forward selects.
module hazard_unit #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic [REG_W-1:0] rd_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             Branch_ID,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EXE_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    logic [REG_W-1:0] rd_exe_q, rd_exe_d, rd_mem_q, rd_wb_q;
    logic [1:0]       op_exe_q, op_exe_d, op_mem_q, op_wb_q;
    logic             st_fwd_exe_q, st_fwd_exe_d, st_fwd_mem_q;

    logic rs1_ld_hit, rs2_ld_hit, is_store, stall;

    function automatic logic [1:0] fwd_sel(
        input logic             use_src,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rd_exe,
        input logic [1:0]       op_exe,
        input logic [REG_W-1:0] rd_mem,
        input logic [1:0]       op_mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && rs != '0) begin
            if (op_exe == OP_ALU && rd_exe == rs)
                sel = FWD_EXE_ALU;
            else if (op_mem == OP_LOAD && rd_mem == rs)
                sel = FWD_MEM_LD;
            else if (op_mem == OP_ALU && rd_mem == rs)
                sel = FWD_MEM_ALU;
        end
        return sel;
    endfunction

    // A load in EXE cannot supply data to ID yet; rd_EXE = 0 never matches.
    always_comb begin
        rs1_ld_hit = rs1use_ID && (op_exe_q == OP_LOAD) && (rd_exe_q != '0) && (rs1_ID == rd_exe_q);
        rs2_ld_hit = rs2use_ID && (op_exe_q == OP_LOAD) && (rd_exe_q != '0) && (rs2_ID == rd_exe_q);
        is_store   = (hazard_optype_ID == OP_STORE);
        // Store data (rs2) can be picked up from the WB load result later instead.
        stall      = rs1_ld_hit || (rs2_ld_hit && !is_store);
    end

    always_comb begin
        rd_exe_d     = rd_ID;
        op_exe_d     = hazard_optype_ID;
        st_fwd_exe_d = is_store && rs2_ld_hit && !rs1_ld_hit;
        if (stall) begin
            rd_exe_d     = '0;
            op_exe_d     = OP_NONE;
            st_fwd_exe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_exe_q     <= '0;
            op_exe_q     <= OP_NONE;
            st_fwd_exe_q <= 1'b0;
            rd_mem_q     <= '0;
            op_mem_q     <= OP_NONE;
            st_fwd_mem_q <= 1'b0;
            rd_wb_q      <= '0;
            op_wb_q      <= OP_NONE;
        end else begin
            rd_exe_q     <= rd_exe_d;
            op_exe_q     <= op_exe_d;
            st_fwd_exe_q <= st_fwd_exe_d;
            rd_mem_q     <= rd_exe_q;
            op_mem_q     <= op_exe_q;
            st_fwd_mem_q <= st_fwd_exe_q;
            rd_wb_q      <= rd_mem_q;
            op_wb_q      <= op_mem_q;
        end
    end

    always_comb begin
        PC_EN_IF        = !stall;
        reg_FD_EN       = !stall;
        reg_DE_flush    = stall;
        // A stalled branch is re-evaluated next cycle with forwarded operands.
        reg_FD_flush    = Branch_ID && !stall;
        forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_ID, rd_exe_q, op_exe_q, rd_mem_q, op_mem_q);
        forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_ID, rd_exe_q, op_exe_q, rd_mem_q, op_mem_q);
        forward_ctrl_ls = st_fwd_mem_q && (op_wb_q == OP_LOAD) && (rd_wb_q != '0);
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven check of hazard_unit: each vector is one ID-stage cycle, its
// expected outputs go through a scoreboard queue and are compared mid-cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rs1use_ID = 1'b0, rs2use_ID = 1'b0;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
    logic [1:0] hazard_optype_ID = '0;
    logic       Branch_ID = 1'b0;
    logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;
    logic       forward_ctrl_ls;

    hazard_unit #(.REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
        .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls)
    );

    always #5 clk = ~clk;

    localparam int NONE = 0, ALU = 1, LD = 2, ST = 3;

    typedef struct {
        string      name;
        bit         pre_rst;
        logic       r1u, r2u;
        logic [4:0] r1, r2, rd;
        logic [1:0] op;
        logic       br;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    // {PC_EN, FD_EN, FD_flush, DE_flush, fwdA, fwdB, ls}
    function automatic logic [9:0] nrm(input int fa, input int fb, input bit ff, input bit ls);
        return {1'b1, 1'b1, ff, 1'b0, 2'(fa), 2'(fb), ls};
    endfunction

    function automatic logic [9:0] stl(input int fa, input int fb);
        return {1'b0, 1'b0, 1'b0, 1'b1, 2'(fa), 2'(fb), 1'b0};
    endfunction

    function automatic vec_t mk(input string nm, input bit pr, input bit r1u, input bit r2u,
                                input int r1, input int r2, input int rd, input int op,
                                input bit br, input logic [9:0] e);
        vec_t v;
        v.name = nm; v.pre_rst = pr; v.r1u = r1u; v.r2u = r2u;
        v.r1 = 5'(r1); v.r2 = 5'(r2); v.rd = 5'(rd); v.op = 2'(op); v.br = br; v.exp = e;
        return v;
    endfunction

    function automatic logic [9:0] actual();
        return {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
                forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
    endfunction

    task automatic drive(input vec_t v);
        rs1use_ID = v.r1u; rs2use_ID = v.r2u;
        rs1_ID = v.r1; rs2_ID = v.r2; rd_ID = v.rd;
        hazard_optype_ID = v.op; Branch_ID = v.br;
    endtask

    task automatic check(input string nm);
        logic [9:0] e, a;
        n_checks++;
        a = actual();
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, actual=%b", nm, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: actual=%b required=%b (pc,fd,ffl,dfl,A,B,ls)", nm, a, e);
            end else
                $display("ok   %s: outputs=%b", nm, a);
        end
    endtask

    initial begin
        // reset state
        vecs.push_back(mk("reset_idle",   1, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        // ALU -> ALU chain
        vecs.push_back(mk("alu_add_x5",   1, 1,1, 1,2,5, ALU, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("alu_sub_x5ex", 0, 1,1, 5,1,6, ALU, 0, nrm(1,0,0,0)));
        vecs.push_back(mk("alu_or_x5mem", 0, 1,1, 5,3,7, ALU, 0, nrm(2,0,0,0)));
        vecs.push_back(mk("alu_and_x5wb", 0, 1,1, 6,5,8, ALU, 0, nrm(2,0,0,0)));
        // load-use on both sources: single stall, then 11/11
        vecs.push_back(mk("lu_lw_x7",     1, 1,0, 2,0,7, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("lu_stall",     0, 1,1, 7,7,8, ALU, 0, stl(0,0)));
        vecs.push_back(mk("lu_release",   0, 1,1, 7,7,8, ALU, 0, nrm(3,3,0,0)));
        vecs.push_back(mk("lu_after",     0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        // load -> store data: no stall, WB load feeds MEM store
        vecs.push_back(mk("ls_lw_x9",     1, 1,0, 2,0,9, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("ls_sw_nostall",0, 1,1, 2,9,0, ST, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("ls_bubble1",   0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("ls_fwd",       0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,1)));
        vecs.push_back(mk("ls_fwd_done",  0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        // load -> store address: stall
        vecs.push_back(mk("sa_lw_x9",     1, 1,0, 2,0,9, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("sa_stall",     0, 1,1, 9,3,0, ST, 0, stl(0,0)));
        vecs.push_back(mk("sa_release",   0, 1,1, 9,3,0, ST, 0, nrm(3,0,0,0)));
        vecs.push_back(mk("sa_no_ls",     0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("sa_no_ls2",    0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        // branch without hazard
        vecs.push_back(mk("br_flush",     1, 1,1, 1,2,0, NONE, 1, nrm(0,0,1,0)));
        vecs.push_back(mk("br_oneshot",   0, 0,0, 0,0,0, NONE, 0, nrm(0,0,0,0)));
        // branch with load-use on rs1: stall wins, then flush
        vecs.push_back(mk("bl_lw_x4",     1, 1,0, 2,0,4, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("bl_stall",     0, 1,1, 4,1,0, NONE, 1, stl(0,0)));
        vecs.push_back(mk("bl_flush",     0, 1,1, 4,1,0, NONE, 1, nrm(3,0,1,0)));
        // x0 writers and priority
        vecs.push_back(mk("x0_add",       1, 1,1, 1,2,0, ALU, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("x0_nofwd",     0, 1,1, 0,0,3, ALU, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("pr_lw_x10",    0, 1,0, 2,0,10, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("pr_add_x10",   0, 1,1, 1,2,10, ALU, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("pr_exe_wins",  0, 1,1, 10,10,11, ALU, 0, nrm(1,1,0,0)));
        vecs.push_back(mk("x0_lw",        0, 1,0, 2,0,0, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("x0_nostall",   0, 1,1, 0,0,1, ALU, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("unused_src",   0, 0,0, 1,1,0, NONE, 0, nrm(0,0,0,0)));
        // bubble with matching indices never stalls or forwards
        vecs.push_back(mk("bub_lw_x12",   1, 1,0, 2,0,12, LD, 0, nrm(0,0,0,0)));
        vecs.push_back(mk("bub_unused",   0, 0,0, 12,12,0, NONE, 0, nrm(0,0,0,0)));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].pre_rst) begin
                drive(mk("idle", 0, 0,0, 0,0,0, NONE, 0, '0));
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            drive(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            #2 check(vecs[i].name);
        end

        // reset asserted mid-stall
        @(negedge clk);
        rst = 1'b1; #1 rst = 1'b0;
        drive(mk("lw", 0, 1,0, 2,0,7, LD, 0, '0));
        exp_q.push_back(nrm(0,0,0,0));
        #2 check("rs_lw_x7");
        @(negedge clk);
        drive(mk("use", 0, 1,1, 7,7,8, ALU, 0, '0));
        exp_q.push_back(stl(0,0));
        #1 check("rs_stall_active");
        rst = 1'b1;
        exp_q.push_back(nrm(0,0,0,0));
        #1 check("rs_async_clear");
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(nrm(0,0,0,0));
        #2 check("rs_held_release");
        @(negedge clk);
        exp_q.push_back(nrm(0,0,0,0));
        #2 check("rs_no_stall_after");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
